// File: rtl/spi_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_controller
//  Description : SPI slave (mode 0, MSB first, active-high select) that parses
//                row-write and load commands and streams pixels into a frame
//                buffer write port. All SPI pins are oversampled on clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int SEGMENTS = 1,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITWIDTH = 8,
    localparam int c_ROW_W = (SEGMENTS * ROWS > 1) ? $clog2(SEGMENTS * ROWS) : 1,
    localparam int c_COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    ss,
    input  logic                    mosi,
    output logic                    miso,
    output logic [c_ROW_W-1:0]      wrow,
    output logic [c_COL_W-1:0]      wcol,
    output logic                    wen,
    output logic [3*BITWIDTH-1:0]   wdata,
    input  logic                    ready,
    output logic                    loaded
);

    // Pixel counter must be able to represent COLUMNS itself (the saturated
    // "row full" value) so that the overflow compare is exact.
    localparam int                 c_CNT_W = $clog2(COLUMNS + 1);
    localparam logic [c_CNT_W-1:0] c_COLS  = c_CNT_W'(COLUMNS);

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,   // next full byte is the command byte
        ST_ROW  = 2'd1,   // collecting pixel byte triples
        ST_SKIP = 2'd2    // unknown/finished command, ignore until ss drops
    } state_t;

    // Input synchronisers / edge history
    logic                   sclk_q;
    logic                   sclk_prev_q;
    logic                   ss_q;
    logic                   ss_prev_q;
    logic                   mosi_q;

    // Byte assembly and command parsing
    logic [6:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    state_t                 state_q;
    logic [1:0]             phase_q;
    logic [7:0]             b0_q;
    logic [7:0]             b1_q;
    logic [c_CNT_W-1:0]     pix_cnt_q;
    logic                   pend_load_q;

    // Registered outputs
    logic [c_ROW_W-1:0]     wrow_q;
    logic [c_COL_W-1:0]     wcol_q;
    logic                   wen_q;
    logic [3*BITWIDTH-1:0]  wdata_q;
    logic                   loaded_q;

    logic                   w_sclk_rise;
    logic [7:0]             w_byte;
    logic                   w_byte_done;
    logic [c_ROW_W-1:0]     w_row;
    logic [3*BITWIDTH-1:0]  w_pix;

    assign w_sclk_rise = sclk_q & ~sclk_prev_q;
    // The byte being completed on this rise: seven shifted bits plus current mosi.
    assign w_byte      = {shift_q, mosi_q};
    assign w_byte_done = (bit_cnt_q == 3'd7);

    // Row number from the command's low nibble, fitted to the row address width.
    generate
        if (c_ROW_W <= 4) begin : g_row_trunc
            assign w_row = w_byte[c_ROW_W-1:0];
        end else begin : g_row_ext
            assign w_row = {{(c_ROW_W-4){1'b0}}, w_byte[3:0]};
        end
    endgenerate

    // Pack the three received bytes into channels of BITWIDTH bits each.
    generate
        if (BITWIDTH == 8) begin : g_chan_exact
            assign w_pix = {b0_q, b1_q, w_byte};
        end else if (BITWIDTH > 8) begin : g_chan_wide
            assign w_pix = {{(BITWIDTH-8){1'b0}}, b0_q,
                            {(BITWIDTH-8){1'b0}}, b1_q,
                            {(BITWIDTH-8){1'b0}}, w_byte};
        end else begin : g_chan_narrow
            assign w_pix = {b0_q[BITWIDTH-1:0], b1_q[BITWIDTH-1:0], w_byte[BITWIDTH-1:0]};
        end
    endgenerate

    // Register the asynchronous SPI pins once and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_q        <= 1'b0;
            ss_prev_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_q      <= sclk;
            sclk_prev_q <= sclk_q;
            ss_q        <= ss;
            ss_prev_q   <= ss_q;
            mosi_q      <= mosi;
        end
    end

    // Command/pixel state machine with registered write-port and load outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= 7'd0;
            bit_cnt_q   <= 3'd0;
            state_q     <= ST_CMD;
            phase_q     <= 2'd0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            pix_cnt_q   <= '0;
            pend_load_q <= 1'b0;
            wrow_q      <= '0;
            wcol_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            loaded_q    <= 1'b0;
        end else begin
            loaded_q <= 1'b0;
            if (!ss_q) begin
                // Deselected: drop any partial byte and restart command parsing.
                bit_cnt_q <= 3'd0;
                state_q   <= ST_CMD;
                phase_q   <= 2'd0;
                wen_q     <= 1'b0;
                // Falling edge of select completes a pending load request.
                if (ss_prev_q && pend_load_q) begin
                    loaded_q    <= ready;
                    pend_load_q <= 1'b0;
                end
            end else if (w_sclk_rise) begin
                // Any new SPI bit ends the write strobe of the previous pixel.
                wen_q     <= 1'b0;
                shift_q   <= w_byte[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (w_byte_done) begin
                    case (state_q)
                        ST_CMD: begin
                            if (w_byte[7:4] == 4'hF) begin
                                wrow_q    <= w_row;
                                wcol_q    <= '0;
                                phase_q   <= 2'd0;
                                pix_cnt_q <= '0;
                                state_q   <= ST_ROW;
                            end else if (w_byte == 8'h10) begin
                                pend_load_q <= 1'b1;
                                state_q     <= ST_SKIP;
                            end else begin
                                state_q <= ST_SKIP;
                            end
                        end
                        ST_ROW: begin
                            case (phase_q)
                                2'd0: begin
                                    b0_q    <= w_byte;
                                    phase_q <= 2'd1;
                                end
                                2'd1: begin
                                    b1_q    <= w_byte;
                                    phase_q <= 2'd2;
                                end
                                default: begin
                                    phase_q <= 2'd0;
                                    // Pixels past the last column are discarded and
                                    // the column address stays on the last column.
                                    if (pix_cnt_q < c_COLS) begin
                                        wdata_q   <= w_pix;
                                        wcol_q    <= pix_cnt_q[c_COL_W-1:0];
                                        wen_q     <= ready;
                                        pix_cnt_q <= pix_cnt_q + 1'b1;
                                    end
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign miso   = 1'b0;
    assign wrow   = wrow_q;
    assign wcol   = wcol_q;
    assign wen    = wen_q;
    assign wdata  = wdata_q;
    assign loaded = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_controller
//  Description : Self-checking bench for spi_controller. An SPI master task
//                drives bytes; a transaction-level model predicts the write
//                port and load strobe from the bytes seen since select rose.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        ready;
    logic        miso;
    logic [2:0]  wrow;
    logic [4:0]  wcol;
    logic        wen;
    logic [23:0] wdata;
    logic        loaded;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  txn_q[$];
    logic        exp_wen;
    logic [23:0] exp_wdata;
    logic [2:0]  exp_wrow;
    logic [4:0]  exp_wcol;

    always #5 clk = ~clk;

    spi_controller dut (
        .clk    (clk),
        .rst    (rst),
        .sclk   (sclk),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso),
        .wrow   (wrow),
        .wcol   (wcol),
        .wen    (wen),
        .wdata  (wdata),
        .ready  (ready),
        .loaded (loaded)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        txn_q.delete();
        exp_wen   = 1'b0;
        exp_wdata = '0;
        exp_wrow  = '0;
        exp_wcol  = '0;
    endtask

    // Predict outputs from the complete byte list of the current transaction.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] cmd;
        int         n;
        int         idx;
        txn_q.push_back(b);
        exp_wen = 1'b0;
        cmd = txn_q[0];
        if (cmd[7:4] == 4'hF) begin
            n = txn_q.size() - 1;
            if (n == 0) begin
                exp_wrow = cmd[2:0];
                exp_wcol = 5'd0;
            end else if (n % 3 == 0) begin
                idx = n / 3 - 1;
                if (idx < 32) begin
                    exp_wdata = {txn_q[n-2], txn_q[n-1], txn_q[n]};
                    exp_wcol  = idx[4:0];
                    exp_wen   = ready;
                end
            end
        end
    endtask

    task automatic check_port(input string ctx);
        check_val({ctx, ".wen"},   {31'd0, wen},   {31'd0, exp_wen});
        check_val({ctx, ".wdata"}, {8'd0, wdata},  {8'd0, exp_wdata});
        check_val({ctx, ".wrow"},  {29'd0, wrow},  {29'd0, exp_wrow});
        check_val({ctx, ".wcol"},  {27'd0, wcol},  {27'd0, exp_wcol});
    endtask

    // Drive n bits MSB first; sclk low 2 clk then high 2 clk per bit.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            sclk = 1'b0;
            step(2);
            sclk = 1'b1;
            step(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        mosi = b[7];
        sclk = 1'b0;
        step(2);
        // Strobe of the previous pixel must survive until the next sclk rise.
        check_val("wen_hold", {31'd0, wen}, {31'd0, exp_wen});
        sclk = 1'b1;
        step(2);
        send_bits(b << 1, 7);
        model_byte(b);
        check_port("byte");
    endtask

    task automatic begin_txn();
        ss = 1'b1;
        step(2);
    endtask

    // Drop select and check the load strobe lands exactly in cycle T1..T2.
    task automatic end_txn();
        logic       exp_ld;
        logic [7:0] cmd;
        exp_ld = 1'b0;
        if (txn_q.size() > 0) begin
            cmd    = txn_q[0];
            exp_ld = (cmd == 8'h10) && ready;
        end
        sclk = 1'b0;
        step(2);
        ss = 1'b0;
        step(1);
        check_val("loaded_T0", {31'd0, loaded}, 32'd0);
        step(1);
        check_val("loaded_T1", {31'd0, loaded}, {31'd0, exp_ld});
        step(1);
        check_val("loaded_T2", {31'd0, loaded}, 32'd0);
        check_val("wen_ss_low", {31'd0, wen}, 32'd0);
        txn_q.delete();
        exp_wen = 1'b0;
    endtask

    task automatic send_frame(input int npix);
        for (int r = 0; r < 8; r++) begin
            begin_txn();
            send_byte(8'hF0 | 8'(r));
            for (int p = 0; p < npix; p++) begin
                send_byte(8'($urandom));
                send_byte(8'($urandom));
                send_byte(8'($urandom));
            end
            end_txn();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        sclk  = 1'b0;
        ss    = 1'b0;
        mosi  = 1'b0;
        ready = 1'b1;
        model_reset();
        step(3);
        check_port("reset");
        check_val("reset.loaded", {31'd0, loaded}, 32'd0);
        check_val("reset.miso",   {31'd0, miso},   32'd0);
        rst = 1'b0;
        step(2);

        // Row 0, pixels {FF,FF,i}
        begin_txn();
        send_byte(8'hF0);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'hFF); send_byte(8'hFF); send_byte(8'(i));
        end
        end_txn();

        // Row 1 full, rows 2..7 short
        begin_txn();
        send_byte(8'hF1);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h00); send_byte(8'hED); send_byte(8'(i));
        end
        end_txn();
        for (int j = 2; j < 8; j++) begin
            begin_txn();
            send_byte(8'hF0 | 8'(j));
            for (int i = 0; i < 4; i++) begin
                send_byte(8'(j)); send_byte(8'hED); send_byte(8'(i));
            end
            end_txn();
        end

        // Load with ready high
        ready = 1'b1;
        begin_txn();
        send_byte(8'h10);
        end_txn();

        // Consumer stalled: no writes and no load strobe
        ready = 1'b0;
        send_frame(8);
        repeat (2) begin
            begin_txn();
            send_byte(8'h10);
            end_txn();
        end

        // Consumer back: full frame then a single load pulse
        ready = 1'b1;
        send_frame(32);
        begin_txn();
        send_byte(8'h10);
        end_txn();

        // Overflow: 34 pixels into a 32-column row
        begin_txn();
        send_byte(8'hF5);
        for (int i = 0; i < 34; i++) begin
            send_byte(8'($urandom)); send_byte(8'($urandom)); send_byte(8'(i));
        end
        end_txn();

        // Reset in the middle of a byte
        begin_txn();
        send_bits(8'hA5, 4);
        sclk = 1'b0;
        rst  = 1'b1;
        step(2);
        model_reset();
        check_port("midrst");
        rst = 1'b0;
        step(2);
        send_byte(8'hF3);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        end_txn();

        // Select dropped for one clock in the middle of a byte
        begin_txn();
        send_bits(8'hFF, 5);
        sclk = 1'b0;
        step(1);
        ss = 1'b0;
        step(1);
        ss = 1'b1;
        txn_q.delete();
        exp_wen = 1'b0;
        step(2);
        send_byte(8'hF3);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
        end_txn();

        // Randomised transactions
        for (int t = 0; t < 12; t++) begin
            int         kind;
            int         nb;
            logic [7:0] cmd;
            ready = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 3);
            if (kind <= 1) begin
                cmd = 8'hF0 | 8'($urandom_range(0, 15));
            end else if (kind == 2) begin
                cmd = 8'h10;
            end else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd[7:4] == 4'hF || cmd == 8'h10) cmd = 8'h22;
            end
            nb = $urandom_range(0, 20);
            begin_txn();
            send_byte(cmd);
            repeat (nb) send_byte(8'($urandom));
            end_txn();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
